axis_result_tx: RTL

- AXI-Stream master transmitter for network results; the outbound counterpart of the zyNet AXI-Stream slave input.
- Accepts the final layer's parallel output vector and the winning class index, each as a one-cycle pulse.
- Serialises them as one packet: NUM_OUT data beats plus an optional class-index beat, with TLAST on the final beat.
- Sits beside the top level, fed by layer-4 outputs and maxFinder; drives a DMA S2MM or another consumer.

---
 rtl/axis_result_tx_pkg.sv | 17 +
 rtl/axis_result_tx_result_slot.sv | 41 ++++
 rtl/axis_result_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/axis_result_tx_pkg.sv
// Shared constants, state encoding and beat-count helper for the result transmitter.
package axis_result_tx_pkg;

  localparam int dataWidth       = 16;
  localparam int numNeuronLayer4 = 10;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Beats per packet: one per neuron, plus the class-index beat when appended.
  function automatic int beats_of(input int num_out, input int append_idx);
    return num_out + ((append_idx != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/axis_result_tx_result_slot.sv
// Registered vector + index holder with a valid flag; load wins over clear.
module result_slot
  import axis_result_tx_pkg::*;
#(
  parameter int VEC_W = numNeuronLayer4 * dataWidth,
  parameter int IDX_W = dataWidth
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [VEC_W-1:0] i_vec,
  input  logic [IDX_W-1:0] i_idx,
  output logic [VEC_W-1:0] o_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [VEC_W-1:0] r_vec;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vec   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_vec   <= i_vec;
      r_idx   <= i_idx;
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_vec   = r_vec;
  assign o_idx   = r_idx;
  assign o_valid = r_valid;

endmodule

// File: rtl/axis_result_tx.sv
// AXI-Stream master that serialises a result vector (plus optional class index) as one packet.
// Handshake: a beat moves on tvalid && tready; while stalled, tdata/tlast/tuser hold and tvalid stays high.
module axis_result_tx
  import axis_result_tx_pkg::*;
#(
  parameter int DATA_WIDTH = dataWidth,
  parameter int NUM_OUT    = numNeuronLayer4,
  parameter int APPEND_IDX = 1,
  parameter int IDX_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          soft_reset,
  input  logic [NUM_OUT*DATA_WIDTH-1:0] in_data,
  input  logic [IDX_WIDTH-1:0]          class_idx,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output tx_state_t                     dbg_state
);

  localparam int VEC_W  = NUM_OUT * DATA_WIDTH;
  localparam int BEATS  = beats_of(NUM_OUT, APPEND_IDX);
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] IDX_BEAT  = BEAT_W'(NUM_OUT);

  tx_state_t              r_state, w_next_state;
  logic [BEAT_W-1:0]      r_beat, w_next_beat;
  logic [CNT_WIDTH-1:0]   r_drop_count;

  logic                   w_rst;
  logic [DATA_WIDTH-1:0]  w_in_idx;
  logic                   w_tvalid, w_hs, w_last_beat, w_last_hs, w_idx_beat;

  logic                   w_act_load, w_act_clear, w_act_valid;
  logic [VEC_W-1:0]       w_act_vec_d, w_act_vec;
  logic [DATA_WIDTH-1:0]  w_act_idx_d, w_act_idx;
  logic                   w_pend_load, w_pend_clear, w_pend_valid;
  logic [VEC_W-1:0]       w_pend_vec;
  logic [DATA_WIDTH-1:0]  w_pend_idx;
  logic                   w_drop;

  assign w_rst = ~s_axi_aresetn | soft_reset;

  // The index is fitted to the beat width at capture, so slots only hold what is sent.
  generate
    if (IDX_WIDTH >= DATA_WIDTH) begin : g_idx_trunc
      assign w_in_idx = class_idx[DATA_WIDTH-1:0];
    end else begin : g_idx_zext
      assign w_in_idx = {{(DATA_WIDTH-IDX_WIDTH){1'b0}}, class_idx};
    end
  endgenerate

  result_slot #(.VEC_W(VEC_W), .IDX_W(DATA_WIDTH)) u_active (
    .i_clk   (s_axi_aclk),
    .i_rst   (w_rst),
    .i_load  (w_act_load),
    .i_clear (w_act_clear),
    .i_vec   (w_act_vec_d),
    .i_idx   (w_act_idx_d),
    .o_vec   (w_act_vec),
    .o_idx   (w_act_idx),
    .o_valid (w_act_valid)
  );

  result_slot #(.VEC_W(VEC_W), .IDX_W(DATA_WIDTH)) u_pending (
    .i_clk   (s_axi_aclk),
    .i_rst   (w_rst),
    .i_load  (w_pend_load),
    .i_clear (w_pend_clear),
    .i_vec   (in_data),
    .i_idx   (w_in_idx),
    .o_vec   (w_pend_vec),
    .o_idx   (w_pend_idx),
    .o_valid (w_pend_valid)
  );

  assign w_tvalid    = (r_state == SEND);
  assign w_hs        = w_tvalid & m_axis_tready;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_last_hs   = w_hs & w_last_beat;
  assign w_idx_beat  = (APPEND_IDX != 0) && (r_beat == IDX_BEAT);

  always_comb begin
    w_next_state = r_state;
    w_next_beat  = r_beat;
    w_act_load   = 1'b0;
    w_act_clear  = 1'b0;
    w_act_vec_d  = w_act_vec >> DATA_WIDTH;
    w_act_idx_d  = w_act_idx;
    w_pend_load  = 1'b0;
    w_pend_clear = 1'b0;
    w_drop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_act_load   = 1'b1;
          w_act_vec_d  = in_data;
          w_act_idx_d  = w_in_idx;
          w_next_beat  = '0;
          w_next_state = SEND;
        end
      end
      SEND: begin
        if (w_last_hs) begin
          // Chain straight into the next packet when one is waiting: no bubble on tvalid.
          w_next_beat = '0;
          if (w_pend_valid) begin
            w_act_load   = 1'b1;
            w_act_vec_d  = w_pend_vec;
            w_act_idx_d  = w_pend_idx;
            w_pend_load  = in_valid;
            w_pend_clear = ~in_valid;
          end else if (in_valid) begin
            w_act_load  = 1'b1;
            w_act_vec_d = in_data;
            w_act_idx_d = w_in_idx;
          end else begin
            w_act_clear  = 1'b1;
            w_next_state = IDLE;
          end
        end else begin
          if (w_hs) begin
            w_act_load  = 1'b1;
            w_next_beat = r_beat + BEAT_W'(1);
          end
          if (in_valid) begin
            if (!w_pend_valid) w_pend_load = 1'b1;
            else               w_drop      = 1'b1;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (w_rst) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_drop_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_beat  <= w_next_beat;
      if (w_drop && (r_drop_count != {CNT_WIDTH{1'b1}}))
        r_drop_count <= r_drop_count + CNT_WIDTH'(1);
    end
  end

  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tdata  = !w_tvalid ? '0 : (w_idx_beat ? w_act_idx : w_act_vec[DATA_WIDTH-1:0]);
  assign m_axis_tlast  = w_tvalid & w_last_beat;
  assign m_axis_tuser  = w_tvalid & w_idx_beat;
  assign in_ready      = ~w_pend_valid;
  assign busy          = (r_state != IDLE) | w_pend_valid | w_act_valid;
  assign drop_count    = r_drop_count;
  assign dbg_state     = r_state;

endmodule
